// File: rtl/fft_seq_sched.sv
// Butterfly scheduler for an in-place radix-2 DIT FFT: walks stages and butterflies,
// issuing read / butterfly / write strobes and operand + twiddle addresses.
module fft_seq_sched #(
   parameter int unsigned N_LOG2 = 5
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [N_LOG2-1:0] addr_a,
   output logic [N_LOG2-1:0] addr_b,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              bf_valid_in,
   input  logic              bf_valid_out,
   output logic              mem_wr_en,
   output logic [3:0]        stage
);

   localparam int unsigned AW = N_LOG2;
   localparam int unsigned KW = N_LOG2 - 1;
   localparam logic [3:0]  LAST_S = 4'(N_LOG2 - 1);

   typedef enum logic [2:0] {IDLE, RD, EXEC, WAIT, WR, DONE} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic            last_k;
   logic [3:0]      nxt_s;
   logic [KW-1:0]   nxt_k;
   logic [AW-1:0]   nxt_a;
   logic [AW-1:0]   nxt_b;
   logic [KW-1:0]   nxt_tw;

   // Upper operand: butterfly index k with a zero bit inserted at position s.
   function automatic logic [AW-1:0] calc_a(input logic [3:0] s, input logic [KW-1:0] kk);
      logic [AW-1:0] kx;
      logic [AW-1:0] lo;
      kx = AW'(kk);
      lo = (AW'(1) << s) - AW'(1);
      return ((kx >> s) << (s + 4'd1)) | (kx & lo);
   endfunction

   function automatic logic [KW-1:0] calc_tw(input logic [3:0] s, input logic [KW-1:0] kk);
      logic [KW-1:0] lo;
      lo = KW'((AW'(1) << s) - AW'(1));
      return (kk & lo) << (4'(KW) - s);
   endfunction

   // Counters and addresses of the butterfly that follows the current one.
   always_comb begin
      last_k = &k;
      nxt_k  = last_k ? '0 : k + KW'(1);
      nxt_s  = last_k ? stage + 4'd1 : stage;
      nxt_a  = calc_a(nxt_s, nxt_k);
      nxt_b  = nxt_a | (AW'(1) << nxt_s);
      nxt_tw = calc_tw(nxt_s, nxt_k);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state       <= IDLE;
         k           <= '0;
         stage       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_rd_en   <= 1'b0;
         bf_valid_in <= 1'b0;
         mem_wr_en   <= 1'b0;
         addr_a      <= '0;
         addr_b      <= '0;
         tw_addr     <= '0;
      end else begin
         mem_rd_en   <= 1'b0;
         bf_valid_in <= 1'b0;
         mem_wr_en   <= 1'b0;
         done        <= 1'b0;
         if (state != IDLE && abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state     <= RD;
                     k         <= '0;
                     stage     <= '0;
                     busy      <= 1'b1;
                     mem_rd_en <= 1'b1;
                     addr_a    <= '0;
                     addr_b    <= AW'(1);
                     tw_addr   <= '0;
                  end
               end
               RD: begin
                  state       <= EXEC;
                  bf_valid_in <= 1'b1;
               end
               EXEC: state <= WAIT;
               WAIT: begin
                  if (bf_valid_out) begin
                     state     <= WR;
                     mem_wr_en <= 1'b1;
                  end
               end
               WR: begin
                  if (last_k && stage == LAST_S) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= RD;
                     mem_rd_en <= 1'b1;
                     k         <= nxt_k;
                     stage     <= nxt_s;
                     addr_a    <= nxt_a;
                     addr_b    <= nxt_b;
                     tw_addr   <= nxt_tw;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fft_seq_sched.sv
// Directed bench for fft_seq_sched at N_LOG2=3 with a behavioural butterfly of programmable latency.
module tb_fft_seq_sched;

   localparam int unsigned NL = 3;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, mem_rd_en, bf_valid_in, mem_wr_en, bf_valid_out;
   logic [NL-1:0] addr_a, addr_b;
   logic [NL-2:0] tw_addr;
   logic [3:0]    stage;

   int cyc = 0;
   int t0 = 0;
   int lat = 1;
   int resp_at = -100;
   logic resp_q = 1'b0;
   logic spur = 1'b0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int st;
      int a;
      int b;
      int tw;
   } bfly_t;
   bfly_t tbl[12];

   fft_seq_sched #(.N_LOG2(NL)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
      .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
      .bf_valid_in(bf_valid_in), .bf_valid_out(bf_valid_out),
      .mem_wr_en(mem_wr_en), .stage(stage)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   // Butterfly model: answers 'lat' cycles after it sees bf_valid_in.
   always @(negedge ACLK) if (bf_valid_in) resp_at = cyc + lat;
   always @(posedge ACLK) begin
      #1;
      resp_q = (cyc == resp_at);
   end
   assign bf_valid_out = resp_q | spur;

   task automatic chk(input string name, input int r, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s rel=%0d: got %0d expected %0d (t=%0t)", name, r, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_start();
      step();
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag, input int r);
      chk({tag, "_busy"}, r, int'(busy), 0);
      chk({tag, "_done"}, r, int'(done), 0);
      chk({tag, "_rd"}, r, int'(mem_rd_en), 0);
      chk({tag, "_bvin"}, r, int'(bf_valid_in), 0);
      chk({tag, "_wr"}, r, int'(mem_wr_en), 0);
      chk({tag, "_a"}, r, int'(addr_a), 0);
      chk({tag, "_b"}, r, int'(addr_b), 0);
      chk({tag, "_tw"}, r, int'(tw_addr), 0);
      chk({tag, "_stage"}, r, int'(stage), 0);
   endtask

   task automatic chk_bfly(input string tag, input int r, input int bi);
      chk({tag, "_stage"}, r, int'(stage), tbl[bi].st);
      chk({tag, "_a"}, r, int'(addr_a), tbl[bi].a);
      chk({tag, "_b"}, r, int'(addr_b), tbl[bi].b);
      chk({tag, "_tw"}, r, int'(tw_addr), tbl[bi].tw);
   endtask

   // Full transform with 1-cycle butterfly; optional stray start pulse at relative cycle inj.
   task automatic run_full(input int inj);
      do_start();
      for (int r = 1; r <= 51; r++) begin
         int  ph;
         int  bi;
         bit  inb;
         start = (r == inj);
         @(negedge ACLK);
         ph  = (r - 1) % 4;
         bi  = (r - 1) / 4;
         inb = (r <= 48);
         chk("full_busy", r, int'(busy), (r <= 49) ? 1 : 0);
         chk("full_done", r, int'(done), (r == 49) ? 1 : 0);
         chk("full_rd", r, int'(mem_rd_en), (inb && ph == 0) ? 1 : 0);
         chk("full_bvin", r, int'(bf_valid_in), (inb && ph == 1) ? 1 : 0);
         chk("full_wr", r, int'(mem_wr_en), (inb && ph == 3) ? 1 : 0);
         if (inb) chk_bfly("full", r, bi);
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      // Hand-computed N=8 DIT schedule: {stage, addr_a, addr_b, tw_addr}.
      tbl[0]  = '{0, 0, 1, 0};  tbl[1]  = '{0, 2, 3, 0};
      tbl[2]  = '{0, 4, 5, 0};  tbl[3]  = '{0, 6, 7, 0};
      tbl[4]  = '{1, 0, 2, 0};  tbl[5]  = '{1, 1, 3, 2};
      tbl[6]  = '{1, 4, 6, 0};  tbl[7]  = '{1, 5, 7, 2};
      tbl[8]  = '{2, 0, 4, 0};  tbl[9]  = '{2, 1, 5, 1};
      tbl[10] = '{2, 2, 6, 2};  tbl[11] = '{2, 3, 7, 3};

      // Reset state
      step(); step(); step();
      @(negedge ACLK);
      chk_all_zero("reset", 0);
      step();
      ARESET = 1'b0;
      step(); step();

      // Nominal transform: strobes, done, busy window, address schedule
      run_full(0);
      step(); step();

      // Stray start in the 10th cycle must not disturb anything
      run_full(10);
      step(); step();

      // Late butterfly (5 cycles) with a spurious bf_valid_out during RD
      lat = 5;
      do_start();
      spur = 1'b1;
      @(negedge ACLK);
      chk("late_rd", 1, int'(mem_rd_en), 1);
      step();
      spur = 1'b0;
      @(negedge ACLK);
      chk("late_bvin", 2, int'(bf_valid_in), 1);
      step();
      for (int r = 3; r <= 7; r++) begin
         @(negedge ACLK);
         chk("late_wait_wr", r, int'(mem_wr_en), 0);
         chk("late_wait_rd", r, int'(mem_rd_en), 0);
         chk("late_wait_busy", r, int'(busy), 1);
         step();
      end
      @(negedge ACLK);
      chk("late_wr", 8, int'(mem_wr_en), 1);
      chk_bfly("late_wr", 8, 0);
      step();
      abort = 1'b1;
      @(negedge ACLK);
      chk("late_rd2", 9, int'(mem_rd_en), 1);
      chk_bfly("late_rd2", 9, 1);
      step();
      abort = 1'b0;
      @(negedge ACLK);
      chk("late_abort_busy", 10, int'(busy), 0);
      lat = 1;
      for (int i = 0; i < 10; i++) step();

      // Abort in WAIT of the third butterfly, coinciding with bf_valid_out
      do_start();
      for (int r = 1; r <= 10; r++) step();
      abort = 1'b1;
      @(negedge ACLK);
      chk("abort_in_wait_busy", 11, int'(busy), 1);
      chk("abort_in_wait_bvo", 11, int'(bf_valid_out), 1);
      step();
      abort = 1'b0;
      for (int r = 12; r <= 20; r++) begin
         @(negedge ACLK);
         chk("abort_busy", r, int'(busy), 0);
         chk("abort_wr", r, int'(mem_wr_en), 0);
         chk("abort_done", r, int'(done), 0);
         chk("abort_rd", r, int'(mem_rd_en), 0);
         step();
      end
      do_start();
      @(negedge ACLK);
      chk("restart_rd", 1, int'(mem_rd_en), 1);
      chk_bfly("restart", 1, 0);
      step(); step(); step();
      @(negedge ACLK);
      chk("restart_wr", 4, int'(mem_wr_en), 1);
      step();
      abort = 1'b1;
      @(negedge ACLK);
      chk_bfly("restart_k1", 5, 1);
      step();
      abort = 1'b0;
      @(negedge ACLK);
      chk("restart_abort_busy", 6, int'(busy), 0);
      step(); step();

      // start together with abort in IDLE stays idle
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         @(negedge ACLK);
         chk("sa_busy", r, int'(busy), 0);
         chk("sa_rd", r, int'(mem_rd_en), 0);
         step();
      end

      // Reset pulse during WR
      do_start();
      step(); step(); step();
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("rst_wr_pre", 4, int'(mem_wr_en), 1);
      step();
      ARESET = 1'b0;
      @(negedge ACLK);
      chk_all_zero("rst_wr", 5);
      step();
      for (int r = 6; r <= 55; r++) begin
         @(negedge ACLK);
         chk("rst_after_done", r, int'(done), 0);
         chk("rst_after_busy", r, int'(busy), 0);
         step();
      end

      // start while reset held is ignored
      ARESET = 1'b1;
      start = 1'b1;
      step();
      ARESET = 1'b0;
      start = 1'b0;
      for (int r = 1; r <= 2; r++) begin
         @(negedge ACLK);
         chk("rst_start_busy", r, int'(busy), 0);
         chk("rst_start_rd", r, int'(mem_rd_en), 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
